// File: rtl/branch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// branch_sequencer_pkg
// Shared definitions for the conditional-branch sequencer:
//   - state_t    : FSM state encoding
//   - CC_*       : 4-bit condition codes
//   - F_*        : bit positions of N/Z/C/V inside the flags vector
// -----------------------------------------------------------------------------
package branch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_REQ_LO,
        S_REQ_HI,
        S_LOAD,
        S_SKIP1,
        S_SKIP2,
        S_FIN
    } state_t;

    localparam logic [3:0] CC_ALWAYS = 4'd0;   // unconditional
    localparam logic [3:0] CC_ZS     = 4'd1;   // Z
    localparam logic [3:0] CC_ZC     = 4'd2;   // !Z
    localparam logic [3:0] CC_CS     = 4'd3;   // C
    localparam logic [3:0] CC_CC     = 4'd4;   // !C
    localparam logic [3:0] CC_NS     = 4'd5;   // N
    localparam logic [3:0] CC_NC     = 4'd6;   // !N
    localparam logic [3:0] CC_VS     = 4'd7;   // V
    localparam logic [3:0] CC_VC     = 4'd8;   // !V
    localparam logic [3:0] CC_HI     = 4'd9;   // C & !Z
    localparam logic [3:0] CC_LS     = 4'd10;  // !C | Z
    localparam logic [3:0] CC_GE     = 4'd11;  // N == V
    localparam logic [3:0] CC_LT     = 4'd12;  // N != V
    localparam logic [3:0] CC_GT     = 4'd13;  // !Z & (N == V)
    localparam logic [3:0] CC_LE     = 4'd14;  // Z | (N != V)
    localparam logic [3:0] CC_NEVER  = 4'd15;  // never taken

    localparam int F_N = 0;
    localparam int F_Z = 1;
    localparam int F_C = 2;
    localparam int F_V = 3;

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational condition evaluator.
// Ports:
//   cond  in  4 : condition code (CC_* values)
//   flags in  4 : {V, C, Z, N} flags
//   taken out 1 : 1 when the condition holds for the given flags
// -----------------------------------------------------------------------------
module cond_eval (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);
    import branch_sequencer_pkg::*;

    logic n, z, c, v;

    assign n = flags[F_N];
    assign z = flags[F_Z];
    assign c = flags[F_C];
    assign v = flags[F_V];

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_ALWAYS: taken = 1'b1;
            CC_ZS:     taken = z;
            CC_ZC:     taken = !z;
            CC_CS:     taken = c;
            CC_CC:     taken = !c;
            CC_NS:     taken = n;
            CC_NC:     taken = !n;
            CC_VS:     taken = v;
            CC_VC:     taken = !v;
            CC_HI:     taken = c && !z;
            CC_LS:     taken = !c || z;
            CC_GE:     taken = (n == v);
            CC_LT:     taken = (n != v);
            CC_GT:     taken = !z && (n == v);
            CC_LE:     taken = z || (n != v);
            CC_NEVER:  taken = 1'b0;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
// Conditional-branch sequencer. Latches a condition code and the flags on
// start, evaluates the condition, and either fetches a little-endian 16-bit
// target from memory and loads the PC, or steps the PC past the two operand
// bytes.
// Ports:
//   clk       in   1 : system clock, rising edge
//   reset     in   1 : asynchronous, active-high
//   start     in   1 : branch request, sampled only in IDLE
//   cond      in   4 : condition code, captured with start
//   flags     in   4 : {V, C, Z, N}, captured with start
//   bus       in   8 : operand byte, sampled when mem_ack = 1
//   mem_ack   in   1 : memory has placed the requested byte on bus
//   mem_req   out  1 : operand byte request, held until acknowledged
//   pc_inc    out  1 : one-cycle PC increment
//   pc_load   out  1 : one-cycle PC load strobe
//   pc_target out 16 : branch target, valid while pc_load = 1
//   busy      out  1 : high outside IDLE
//   done      out  1 : one-cycle completion pulse
// -----------------------------------------------------------------------------
module branch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  cond,
    input  logic [3:0]  flags,
    input  logic [7:0]  bus,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [15:0] pc_target,
    output logic        busy,
    output logic        done
);
    import branch_sequencer_pkg::*;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cond_q;
    logic [3:0] flags_q;
    logic       taken;

    // Evaluates the latched copies so input changes after start cannot
    // alter the decision of a branch in progress.
    cond_eval u_cond_eval (
        .cond  (cond_q),
        .flags (flags_q),
        .taken (taken)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture registers. The target is assembled directly in pc_target, so it
    // keeps its last value after LOAD; reset discards any partial target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_q    <= 4'h0;
            flags_q   <= 4'h0;
            pc_target <= 16'h0000;
        end else begin
            if (state == S_IDLE && start) begin
                cond_q  <= cond;
                flags_q <= flags;
            end
            if (state == S_REQ_LO && mem_ack) begin
                pc_target[7:0] <= bus;
            end
            if (state == S_REQ_HI && mem_ack) begin
                pc_target[15:8] <= bus;
            end
        end
    end

    // Next-state and output decode. Outputs depend on state only, except the
    // pc_inc that accompanies the low-byte acknowledge.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                state_nxt = taken ? S_REQ_LO : S_SKIP1;
            end
            S_REQ_LO: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_inc    = 1'b1;
                    state_nxt = S_REQ_HI;
                end
            end
            S_REQ_HI: begin
                mem_req = 1'b1;
                if (mem_ack) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                pc_load   = 1'b1;
                state_nxt = S_FIN;
            end
            S_SKIP1: begin
                pc_inc    = 1'b1;
                state_nxt = S_SKIP2;
            end
            S_SKIP2: begin
                pc_inc    = 1'b1;
                state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_branch_sequencer
// Scoreboard bench for branch_sequencer plus a standalone sweep of cond_eval.
// Stimulus pushes the expected outcome of each branch into a queue; a monitor
// accumulates the DUT activity of the branch and compares it when done pulses.
// A memory model answers mem_req with a configurable number of wait cycles.
// -----------------------------------------------------------------------------
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  cond;
    logic [3:0]  flags;
    logic [7:0]  bus;
    logic        mem_ack;
    logic        mem_req;
    logic        pc_inc;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        busy;
    logic        done;

    logic [3:0]  ce_cond;
    logic [3:0]  ce_flags;
    logic        ce_taken;

    branch_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cond      (cond),
        .flags     (flags),
        .bus       (bus),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .busy      (busy),
        .done      (done)
    );

    cond_eval u_ce (
        .cond  (ce_cond),
        .flags (ce_flags),
        .taken (ce_taken)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference for cond_eval: codes 1..14 form pairs (odd = base condition,
    // even = its complement), the base selected by (cond-1)/2.
    function automatic logic ref_taken(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic [6:0] base;
        logic b;
        int idx;
        n  = f[0];
        z  = f[1];
        cy = f[2];
        v  = f[3];
        if (c == 4'd0)  return 1'b1;
        if (c == 4'd15) return 1'b0;
        base = {~z & ~(n ^ v), ~(n ^ v), cy & ~z, v, n, cy, z};
        idx  = (int'(c) - 1) / 2;
        b    = base[idx];
        return c[0] ? b : ~b;
    endfunction

    // ---------------------------------------------------------------- memory
    logic [7:0] mem_bytes [2];
    int         wait_cfg = 0;
    int         wait_cnt;
    int         byte_idx;

    initial begin
        mem_ack  = 1'b0;
        bus      = 8'h00;
        wait_cnt = 0;
        byte_idx = 0;
        forever begin
            @(posedge clk);
            #1;
            // An ack raised while mem_req was high is consumed at that edge.
            if (mem_ack) begin
                byte_idx++;
                wait_cnt = 0;
            end
            if (!busy) begin
                byte_idx = 0;
                wait_cnt = 0;
            end
            mem_ack = 1'b0;
            bus     = 8'hEE;
            if (mem_req && !reset) begin
                if (wait_cnt >= wait_cfg) begin
                    mem_ack = 1'b1;
                    bus     = mem_bytes[byte_idx % 2];
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        int          start_cyc;
        int          done_lat;
        int          load_lat;
        logic [15:0] target;
        int          n_inc;
        int          n_req;
        int          n_load;
    } exp_t;

    exp_t        exp_q[$];
    int          req_cnt = 0;
    int          inc_cnt = 0;
    int          load_cnt = 0;
    int          load_cyc = 0;
    logic [15:0] load_tgt = 16'h0;
    int          done_total = 0;
    int          load_total = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            req_cnt  = 0;
            inc_cnt  = 0;
            load_cnt = 0;
        end else begin
            if (mem_req) req_cnt++;
            if (pc_inc)  inc_cnt++;
            if (pc_load) begin
                load_cnt++;
                load_total++;
                load_cyc = cyc;
                load_tgt = pc_target;
            end
            if (done) begin
                done_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_latency", cyc - e.start_cyc, e.done_lat);
                    check("pc_load_count", load_cnt, e.n_load);
                    check("pc_inc_count", inc_cnt, e.n_inc);
                    check("mem_req_cycles", req_cnt, e.n_req);
                    if (e.n_load > 0 && load_cnt > 0) begin
                        check("pc_load_latency", load_cyc - e.start_cyc, e.load_lat);
                        check("pc_target", load_tgt, e.target);
                    end
                end
                req_cnt  = 0;
                inc_cnt  = 0;
                load_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    // mode 0: plain branch; 1: change flags and re-start during REQ_HI;
    // 2: assert reset during REQ_HI (no outcome expected).
    task automatic run_branch(input logic [3:0] c, input logic [3:0] f,
                              input logic [7:0] lo, input logic [7:0] hi,
                              input int w, input int d_lat, input int l_lat,
                              input int n_inc, input int n_req, input int n_load,
                              input int mode);
        exp_t e;
        int   d0;
        int   l0;
        int   i;
        mem_bytes[0] = lo;
        mem_bytes[1] = hi;
        wait_cfg     = w;
        @(posedge clk);
        #1;
        e.start_cyc = cyc;
        e.done_lat  = d_lat;
        e.load_lat  = l_lat;
        e.target    = {hi, lo};
        e.n_inc     = n_inc;
        e.n_req     = n_req;
        e.n_load    = n_load;
        if (mode != 2) exp_q.push_back(e);
        d0    = done_total;
        l0    = load_total;
        cond  = c;
        flags = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cond  = 4'($urandom_range(0, 15));
        flags = 4'($urandom_range(0, 15));
        if (mode != 0) begin
            i = 0;
            while (i < 100 && mem_ack !== 1'b1) begin
                @(negedge clk);
                i++;
            end
            if (mem_ack !== 1'b1) check("low_byte_ack_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
            if (mode == 1) begin
                flags = ~f;
                cond  = 4'd15;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end else begin
                #2;
                reset = 1'b1;
                #1;
                check("abort_mem_req", mem_req, 1'b0);
                check("abort_pc_inc", pc_inc, 1'b0);
                check("abort_pc_load", pc_load, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                check("abort_pc_target", pc_target, 16'h0000);
                repeat (3) @(negedge clk);
                reset = 1'b0;
                repeat (10) @(negedge clk);
                check("abort_no_done", done_total - d0, 32'd0);
                check("abort_no_pc_load", load_total - l0, 32'd0);
            end
        end
        if (mode != 2) begin
            i = 0;
            while (i < 100 && done_total == d0) begin
                @(negedge clk);
                i++;
            end
            if (done_total == d0) check("done_timeout", 32'd0, 32'd1);
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        cond     = 4'h0;
        flags    = 4'h0;
        ce_cond  = 4'h0;
        ce_flags = 4'h0;
        #3;
        check("reset_mem_req", mem_req, 1'b0);
        check("reset_pc_inc", pc_inc, 1'b0);
        check("reset_pc_load", pc_load, 1'b0);
        check("reset_pc_target", pc_target, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);

        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                ce_cond  = c[3:0];
                ce_flags = f[3:0];
                #1;
                check($sformatf("cond_eval_c%0d_f%0d", c, f), ce_taken, ref_taken(c[3:0], f[3:0]));
            end
        end
        ce_cond  = 4'd13;
        ce_flags = 4'b0000;
        #1;
        check("spot_cond13_f0000", ce_taken, 1'b1);
        ce_flags = 4'b1000;
        #1;
        check("spot_cond13_f1000", ce_taken, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        //          cond   flags    lo     hi     w  done load inc req ld mode
        run_branch(4'd1,  4'b0010, 8'h34, 8'h12, 0,  5,   4,  1,  2, 1, 0);
        run_branch(4'd2,  4'b0010, 8'h34, 8'h12, 0,  4,   0,  2,  0, 0, 0);
        run_branch(4'd1,  4'b0010, 8'hCD, 8'hAB, 3, 11,  10,  1,  8, 1, 0);
        run_branch(4'd1,  4'b0010, 8'h78, 8'h56, 2,  9,   8,  1,  6, 1, 1);
        run_branch(4'd1,  4'b0010, 8'h11, 8'h22, 3,  0,   0,  0,  0, 0, 2);
        run_branch(4'd0,  4'b0000, 8'h0F, 8'hF0, 0,  5,   4,  1,  2, 1, 0);
        run_branch(4'd15, 4'b1111, 8'h99, 8'h88, 0,  4,   0,  2,  0, 0, 0);
        run_branch(4'd13, 4'b1000, 8'h99, 8'h88, 0,  4,   0,  2,  0, 0, 0);
        run_branch(4'd12, 4'b0001, 8'hA5, 8'h5A, 1,  7,   6,  1,  4, 1, 0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Conditional-branch sequencer: the consumer side of the flags register. It evaluates a 4-bit condition code against the latched N/Z/C/V flags and, for a taken branch, fetches the 16-bit target operand from the data bus one byte at a time and loads the program counter. For a not-taken branch it steps the PC past the two operand bytes. It sits between the instruction decoder, the flags register output, memory and the PC.

## Interface
- No parameters; all widths are fixed: flags 4, condition 4, bus 8, target 16.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and clears all outputs and registers.
- `start` in 1: one-cycle request from the decoder, sampled only in IDLE.
- `cond` in 4: condition code, captured with `start`.
- `flags` in 4: flags register output; bit0 = N, bit1 = Z, bit2 = C, bit3 = V; captured with `start`.
- `bus` in 8: data bus carrying operand bytes; sampled when `mem_ack` = 1.
- `mem_ack` in 1: memory has placed the requested byte on `bus`.
- `mem_req` out 1: operand byte read request, held until acknowledged.
- `pc_inc` out 1: one-cycle PC increment pulse.
- `pc_load` out 1: one-cycle PC load strobe.
- `pc_target` out 16: branch target; valid while `pc_load` = 1.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- Condition codes:
  - 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 !N; 7 V; 8 !V
  - 9 C&!Z; 10 !C|Z
  - 11 N==V; 12 N!=V; 13 !Z&(N==V); 14 Z|(N!=V)
  - 15 never
- `cond` and `flags` are latched at `start`. Later changes to the inputs do not affect the branch in progress.
- States and transitions:
  - IDLE: on `start` → EVAL.
  - EVAL: evaluate the condition; taken → REQ_LO, not taken → SKIP1.
  - REQ_LO: assert `mem_req`; on `mem_ack` capture `bus` into target[7:0], pulse `pc_inc`, go to REQ_HI.
  - REQ_HI: assert `mem_req`; on `mem_ack` capture `bus` into target[15:8], go to LOAD.
  - LOAD: `pc_load` = 1 with the full target; → FIN.
  - SKIP1: `pc_inc` = 1; → SKIP2.
  - SKIP2: `pc_inc` = 1; → FIN.
  - FIN: `done` = 1; → IDLE.
- Little-endian target: low byte first.
- `start` while `busy` = 1 is ignored, not queued.

## Timing
- Reset values: `mem_req`, `pc_inc`, `pc_load`, `busy`, `done` = 0; `pc_target` = 16'h0000; state IDLE.
- All outputs are Moore (registered state decode), except that `pc_inc` in REQ_LO coincides with the `mem_ack` cycle.
- Not-taken latency: `start` at cycle 0, EVAL at 1, SKIP1 at 2, SKIP2 at 3, `done` at 4.
- Taken latency with zero-wait memory (`mem_ack` high in the same cycle as `mem_req`): EVAL at 1, REQ_LO at 2, REQ_HI at 3, LOAD at 4, `done` at 5. Each wait cycle adds one cycle.
- `mem_req` stays high and steady until `mem_ack` is seen. `mem_ack` outside REQ_LO/REQ_HI is ignored.
- `pc_target` holds its last value after LOAD until the next capture.
- `reset` mid-operation: immediate return to IDLE, outputs cleared, partial target discarded. No `done` or `pc_load` is ever emitted for an aborted branch.

## Structure
- A shared package holds:
  - the state encoding (IDLE, EVAL, REQ_LO, REQ_HI, LOAD, SKIP1, SKIP2, FIN);
  - condition-code constants `CC_ALWAYS` … `CC_NEVER`;
  - flag bit indices `F_N` = 0, `F_Z` = 1, `F_C` = 2, `F_V` = 3.
- One combinational sub-module, `cond_eval` (inputs cond[3:0] and flags[3:0], output taken), is tested standalone.
- The FSM, capture registers and output decode live in `branch_sequencer`.

## Test plan
- Exhaustive `cond_eval`: all 16 conds × 16 flag values compared with a reference model. Spot checks: cond 13 with flags 4'b0000 → taken; cond 13 with 4'b1000 → not taken.
- Taken, zero-wait: cond 1, flags 4'b0010, bus bytes 8'h34 then 8'h12 → `pc_load` at cycle 4 with `pc_target` = 16'h1234, one `pc_inc`, `done` at cycle 5.
- Not taken: cond 2, flags 4'b0010 → no `mem_req`, `pc_inc` high in cycles 2–3, `done` at 4, no `pc_load`.
- Wait states: `mem_ack` delayed 3 cycles on each byte → `mem_req` held steady throughout, target correct, `done` 6 cycles later than in the zero-wait case.
- Flag change and re-`start` mid-branch: `flags` altered and `start` pulsed during REQ_HI → original decision kept, second `start` ignored.
- `reset` asserted in REQ_HI → all outputs 0 asynchronously, no `pc_load`/`done`; a following `start` completes normally.
